// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV64 instruction encoder.
// Packs decoded fields into a 32-bit instruction word.
// The result goes through a 2-entry output FIFO with valid/ready handshakes on both sides.
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN. When it is defined, immediates that
// cannot be represented in the selected format set the error flag.
module instr_encoder #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [6:0]   in_opcode,
   input  logic [4:0]   in_rd,
   input  logic [4:0]   in_rs1,
   input  logic [4:0]   in_rs2,
   input  logic [2:0]   in_funct3,
   input  logic [6:0]   in_funct7,
   input  logic [N-1:0] in_imm,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_instr,
   output logic         out_err,
   output logic [15:0]  enc_count,
   output logic [15:0]  err_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] enc_instr;
   logic        enc_err;
   logic        rng_i, rng_b, rng_u, rng_j;

`ifdef INSTR_ENC_RANGE_CHECK_EN
   // A sign-extended immediate fits in k+1 bits when every bit from k upward is identical.
   assign rng_i = ~((&in_imm[N-1:11]) | ~(|in_imm[N-1:11]));
   assign rng_b = ~((&in_imm[N-1:12]) | ~(|in_imm[N-1:12])) | in_imm[0];
   assign rng_u = ~((&in_imm[N-1:31]) | ~(|in_imm[N-1:31])) | (|in_imm[11:0]);
   assign rng_j = ~((&in_imm[N-1:20]) | ~(|in_imm[N-1:20])) | in_imm[0];
`else
   // Immediates are silently truncated. The upper immediate bits have no consumer.
   logic unused_imm_hi;
   assign unused_imm_hi = ^in_imm[N-1:32];
   assign rng_i = 1'b0;
   assign rng_b = 1'b0;
   assign rng_u = 1'b0;
   assign rng_j = 1'b0;
`endif

   // Select the format from the opcode and scatter the immediate bits.
   always_comb begin
      enc_instr = NOP;
      enc_err   = 1'b0;
      case (in_opcode)
         7'b0010011, 7'b0011011, 7'b1100111, 7'b0000011: begin
            enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            enc_err   = rng_i;
         end
         7'b0110011, 7'b0111011: begin
            enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         end
         7'b0100011: begin
            enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            enc_err   = rng_i;
         end
         7'b1100011: begin
            enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
            enc_err   = rng_b;
         end
         7'b0110111, 7'b0010111: begin
            enc_instr = {in_imm[31:12], in_rd, in_opcode};
            enc_err   = rng_u;
         end
         7'b1101111: begin
            enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            enc_err   = rng_j;
         end
         default: begin
            enc_instr = NOP;
            enc_err   = 1'b1;
         end
      endcase
   end

   // FIFO state: two 33-bit slots {err, instr} with read/write pointers and an occupancy count.
   logic [32:0] mem_q [2];
   logic [32:0] mem_d [2];
   logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] enc_cnt_q, enc_cnt_d, err_cnt_q, err_cnt_d;
   logic        push, pop;

   // in_ready comes from registered occupancy only, so out_ready has no path to it.
   assign in_ready  = (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
   assign out_err   = out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
   assign enc_count = enc_cnt_q;
   assign err_count = err_cnt_q;

   // Next state for the FIFO and the saturating counters.
   always_comb begin
      mem_d[0]  = mem_q[0];
      mem_d[1]  = mem_q[1];
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      enc_cnt_d = enc_cnt_q;
      err_cnt_d = err_cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = {enc_err, enc_instr};
         wr_ptr_d        = ~wr_ptr_q;
         if (enc_cnt_q != 16'hFFFF) enc_cnt_d = enc_cnt_q + 16'd1;
         if (enc_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers. Reset discards buffered words and clears the counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         enc_cnt_q <= 16'd0;
         err_cnt_q <= 16'd0;
      end else begin
         mem_q[0]  <= mem_d[0];
         mem_q[1]  <= mem_d[1];
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         enc_cnt_q <= enc_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder.
// The stimulus process pushes expectations into a queue.
// A separate monitor pops an expectation on every output transfer and checks it.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [63:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic        out_err;
   logic [15:0] enc_count, err_count;

   always #5 clk = ~clk;

   instr_encoder #(.N(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err),
      .enc_count(enc_count), .err_count(err_count)
   );

   // fmt: 0=I 1=S 2=B 3=U 4=J 5=R
   typedef struct {
      logic [31:0] instr;
      logic        err;
      logic        chk_instr;
      logic        chk_imm;
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic [6:0]  op;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_enc = 0;
   int   exp_errc = 0;
   logic sat_mode = 1'b0;

`ifdef INSTR_ENC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Recover the immediate from an encoded word.
   function automatic logic [63:0] extract(input logic [31:0] i, input logic [2:0] fmt);
      logic [11:0] t12;
      logic [12:0] t13;
      logic [20:0] t21;
      logic [31:0] t32;
      case (fmt)
         3'd0: begin t12 = i[31:20]; return {{52{t12[11]}}, t12}; end
         3'd1: begin t12 = {i[31:25], i[11:7]}; return {{52{t12[11]}}, t12}; end
         3'd2: begin t13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; return {{51{t13[12]}}, t13}; end
         3'd3: begin t32 = {i[31:12], 12'b0}; return {{32{t32[31]}}, t32}; end
         default: begin t21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; return {{43{t21[20]}}, t21}; end
      endcase
   endfunction

   // Monitor: compare every output transfer against the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && !sat_mode && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_unexpected: got word %h, expected none", out_instr);
         end else begin
            e = sb.pop_front();
            if (e.chk_instr) check("instr", {32'h0, out_instr}, {32'h0, e.instr});
            check("err", {63'h0, out_err}, {63'h0, e.err});
            if (e.chk_imm) begin
               check("rt_imm", extract(out_instr, e.fmt), e.imm);
               check("rt_op", {57'h0, out_instr[6:0]}, {57'h0, e.op});
            end
         end
      end
   end

   // Present one bundle and wait (bounded) until it is accepted.
   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] imm, input exp_t e);
      int t = 0;
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (!in_ready) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: in_ready 0, expected 1 within 50 cycles");
      end else begin
         sb.push_back(e);
         exp_enc++;
         if (e.err) exp_errc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   function automatic exp_t mk(input logic [31:0] instr, input logic err);
      exp_t e;
      e.instr = instr; e.err = err; e.chk_instr = 1'b1; e.chk_imm = 1'b0;
      e.fmt = 3'd0; e.imm = '0; e.op = instr[6:0];
      return e;
   endfunction

   task automatic drain();
      int t = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && t < 20) begin @(posedge clk); t++; end
      #1;
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      exp_t e;
      logic [6:0]  ops_i[4];
      logic [6:0]  op;
      logic [63:0] imm;
      logic [31:0] r;
      logic [31:0] head;
      int fmt;
      ops_i[0] = 7'b0010011; ops_i[1] = 7'b0011011; ops_i[2] = 7'b1100111; ops_i[3] = 7'b0000011;

      // Reset state
      #1;
      check("rst_out_valid", {63'h0, out_valid}, 64'd0);
      check("rst_out_instr", {32'h0, out_instr}, 64'd0);
      check("rst_out_err",   {63'h0, out_err}, 64'd0);
      check("rst_enc_count", {48'h0, enc_count}, 64'd0);
      check("rst_err_count", {48'h0, err_count}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1 check("in_ready_after_rst", {63'h0, in_ready}, 64'd1);
      @(posedge clk); #1;

      // addi x1, x0, -1 -- word visible one cycle after accept
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, mk(32'hFFF00093, 1'b0));
      check("addi_latency_valid", {63'h0, out_valid}, 64'd1);
      // sw x2, 8(x1)
      send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 64'd8, mk(32'h0020A423, 1'b0));
      // jal x1, 2048
      send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, mk(32'h001000EF, 1'b0));
      // lui x5, 0x12345000 and the misaligned variant
      send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000, mk(32'h123452B7, 1'b0));
      send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345001, mk(32'h123452B7, RC));
      // addi with out-of-range immediate 2048: truncated to 0x800
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, mk(32'h80000093, RC));
      // add x3, x1, x2 (R-type, immediate ignored)
      send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'hDEAD_BEEF_0000_0001, mk(32'h002081B3, 1'b0));
      // unknown opcode
      send(7'b1111111, 5'd3, 5'd1, 5'd2, 3'd7, 7'h7F, 64'd5, mk(32'h00000013, 1'b1));
      drain();
      check("enc_count_directed", {48'h0, enc_count}, 64'(exp_enc));
      check("err_count_directed", {48'h0, err_count}, 64'(exp_errc));

      // Backpressure: two words accepted, third stalls, head holds stable
      out_ready = 1'b0;
      send(7'b0010011, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 64'd5, mk(32'h00518113, 1'b0));
      send(7'b0010011, 5'd4, 5'd3, 5'd0, 3'd0, 7'd0, 64'd6, mk(32'h00618213, 1'b0));
      in_opcode = 7'b0010011; in_rd = 5'd6; in_rs1 = 5'd3; in_imm = 64'd7; in_valid = 1'b1;
      head = 32'h00518113;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", {63'h0, in_ready}, 64'd0);
         check("bp_head_stable", {32'h0, out_instr}, {32'h0, head});
      end
      check("bp_enc_count", {48'h0, enc_count}, 64'(exp_enc));
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(7'b0010011, 5'd6, 5'd3, 5'd0, 3'd0, 7'd0, 64'd7, mk(32'h00718313, 1'b0));
      drain();
      check("bp_in_ready_back", {63'h0, in_ready}, 64'd1);

      // Reset mid-operation with two buffered words
      out_ready = 1'b0;
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, mk(32'h00100093, 1'b0));
      send(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, mk(32'h00000013, 1'b1));
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {63'h0, out_valid}, 64'd0);
      check("midrst_enc_count", {48'h0, enc_count}, 64'd0);
      check("midrst_err_count", {48'h0, err_count}, 64'd0);
      sb.delete();
      exp_enc = 0; exp_errc = 0;
      @(posedge clk); #1 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Round trip over all formats with in-range immediates
      for (int k = 0; k < 30; k++) begin
         fmt = k % 6;
         r = $urandom;
         e.chk_instr = 1'b0; e.chk_imm = 1'b1; e.err = 1'b0; e.instr = '0; e.fmt = 3'(fmt);
         case (fmt)
            0: begin op = ops_i[r[1:0]]; imm = {{52{r[11]}}, r[11:0]}; end
            1: begin op = 7'b0100011; imm = {{52{r[11]}}, r[11:0]}; end
            2: begin op = 7'b1100011; imm = {{51{r[12]}}, r[12:1], 1'b0}; end
            3: begin op = r[31] ? 7'b0110111 : 7'b0010111; imm = {{32{r[30]}}, r[30:11], 12'b0}; end
            4: begin op = 7'b1101111; imm = {{43{r[20]}}, r[20:1], 1'b0}; end
            default: begin
               op = r[0] ? 7'b0110011 : 7'b0111011; imm = {r, ~r};
               e.chk_instr = 1'b1; e.chk_imm = 1'b0;
               e.instr = {r[31:25], r[24:20], r[19:15], r[14:12], r[11:7], op};
            end
         endcase
         e.imm = imm; e.op = op;
         send(op, r[11:7], r[19:15], r[24:20], r[14:12], r[31:25], imm, e);
      end
      drain();
      check("rt_enc_count", {48'h0, enc_count}, 64'(exp_enc));
      check("rt_err_count", {48'h0, err_count}, 64'd0);

      // Counter saturation: one transfer per cycle with unknown opcodes
      rst = 1'b1; #1; sb.delete();
      @(posedge clk); #1 rst = 1'b0;
      sat_mode = 1'b1;
      in_opcode = 7'b1111111; in_valid = 1'b1; out_ready = 1'b1;
      repeat (1000) @(posedge clk);
      #1;
      check("sat_mid_enc", {48'h0, enc_count}, 64'd1000);
      check("sat_mid_err", {48'h0, err_count}, 64'd1000);
      repeat (64600) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("sat_enc", {48'h0, enc_count}, 64'hFFFF);
      check("sat_err", {48'h0, err_count}, 64'hFFFF);
      repeat (3) @(posedge clk);
      #1;
      check("sat_hold_enc", {48'h0, enc_count}, 64'hFFFF);
      check("sat_drained", {63'h0, out_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
